// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared definitions for the load/store unit: RISC-V funct3 width
//            codes, FSM state and error-code enums, and the access-size
//            byte-mask helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Load funct3 codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Store funct3 codes
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_SD  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RESP     = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ILLEGAL  = 2'b11
  } lsu_err_e;

  // Byte mask for an access of 2**sz bytes, anchored at lane 0.
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Combinational byte-lane steering for the load/store unit.
//            Builds byte enables and lane-shifted store data, and extracts
//            and sign/zero-extends load data from the returned word.
// Ports    : funct3_i      access width/sign code
//            offset_i      byte offset of the access within the word
//            store_data_i  unshifted store value
//            rdata_i       raw word returned by memory
//            be_o          byte enables
//            wdata_o       store data shifted to its lanes
//            load_data_o   extracted, extended load value
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [2:0]          funct3_i,
  input  logic [OFF_W-1:0]    offset_i,
  input  logic [XLEN-1:0]     store_data_i,
  input  logic [XLEN-1:0]     rdata_i,
  output logic [XLEN/8-1:0]   be_o,
  output logic [XLEN-1:0]     wdata_o,
  output logic [XLEN-1:0]     load_data_o
);

  logic [OFF_W+2:0] w_bit_shift;
  logic [XLEN-1:0]  w_shifted;

  assign w_bit_shift = {offset_i, 3'b000};
  assign be_o        = (XLEN/8)'(size_mask(funct3_i[1:0])) << offset_i;
  // Upper bytes beyond the access size land in disabled lanes, so no masking.
  assign wdata_o     = store_data_i << w_bit_shift;
  assign w_shifted   = rdata_i >> w_bit_shift;

  // Extension is built at 64 bits and truncated so one description serves
  // both XLEN=32 and XLEN=64.
  always_comb begin
    load_data_o = w_shifted;
    case (funct3_i)
      F3_LB:   load_data_o = XLEN'({{56{w_shifted[7]}},  w_shifted[7:0]});
      F3_LH:   load_data_o = XLEN'({{48{w_shifted[15]}}, w_shifted[15:0]});
      F3_LW:   load_data_o = XLEN'({{32{w_shifted[31]}}, w_shifted[31:0]});
      F3_LBU:  load_data_o = XLEN'({56'b0, w_shifted[7:0]});
      F3_LHU:  load_data_o = XLEN'({48'b0, w_shifted[15:0]});
      F3_LWU:  load_data_o = XLEN'({32'b0, w_shifted[31:0]});
      default: load_data_o = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : MEM-stage load/store unit. Accepts one op from EX, performs a
//            req/gnt/rvalid data-memory access with response timeout, or
//            bypasses the ALU result, and retires with a one-cycle done pulse.
// Ports    : ex_*        op handshake and operands from EX
//            done_o/wb_* retire pulse and writeback data
//            err_*       fault flag, code and address (valid with done_o)
//            dmem_*      data-memory request/response port
// Config   : LSU_MISALIGN_TRAP_EN - misaligned ops fault with code 01 instead
//            of being aligned down to the access size.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int RSP_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid_i,
  output logic                ex_ready_o,
  input  logic                mem_read_en_i,
  input  logic                mem_write_en_i,
  input  logic [2:0]          funct3_i,
  input  logic [XLEN-1:0]     alu_result_i,
  input  logic [XLEN-1:0]     store_data_i,
  output logic                done_o,
  output logic                wb_we_o,
  output logic [XLEN-1:0]     wb_data_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [ADDR_W-1:0]   err_addr_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [ADDR_W-1:0]   dmem_addr_o,
  output logic [XLEN/8-1:0]   dmem_be_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i
);

  localparam int OFF_W = $clog2(XLEN / 8);
  localparam int CNT_W = $clog2(RSP_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

  lsu_state_e          state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     sdata_q, sdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wb_we_q, wb_we_d;
  logic [XLEN-1:0]     wb_data_q, wb_data_d;
  logic                err_q, err_d;
  lsu_err_e            err_code_q, err_code_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;

  logic [ADDR_W-1:0]   w_addr_raw;
  logic [ADDR_W-1:0]   w_addr_algn;
  logic [OFF_W-1:0]    w_amask;
  logic                w_legal;
  logic [XLEN/8-1:0]   w_be;
  logic [XLEN-1:0]     w_wdata;
  logic [XLEN-1:0]     w_load_data;
  logic                w_req;
  logic                w_resp;

  assign w_addr_raw  = ADDR_W'(alu_result_i);
  // Low offset bits that must be zero for a naturally aligned access.
  assign w_amask     = OFF_W'((4'd1 << funct3_i[1:0]) - 4'd1);
  assign w_addr_algn = {w_addr_raw[ADDR_W-1:OFF_W], w_addr_raw[OFF_W-1:0] & ~w_amask};

`ifdef LSU_MISALIGN_TRAP_EN
  logic w_mis;
  assign w_mis = |(w_addr_raw[OFF_W-1:0] & w_amask);
`endif

  // Width/sign legality; 64-bit and LWU forms exist only when XLEN=64.
  always_comb begin
    w_legal = 1'b0;
    if (mem_read_en_i && !mem_write_en_i) begin
      case (funct3_i)
        F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: w_legal = 1'b1;
        F3_LD, F3_LWU:                       w_legal = (XLEN == 64);
        default:                             w_legal = 1'b0;
      endcase
    end else if (mem_write_en_i && !mem_read_en_i) begin
      case (funct3_i)
        F3_SB, F3_SH, F3_SW: w_legal = 1'b1;
        F3_SD:               w_legal = (XLEN == 64);
        default:             w_legal = 1'b0;
      endcase
    end
  end

  lsu_lane_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_lane_align (
    .funct3_i     (f3_q),
    .offset_i     (addr_q[OFF_W-1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (dmem_rdata_i),
    .be_o         (w_be),
    .wdata_o      (w_wdata),
    .load_data_o  (w_load_data)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    sdata_d    = sdata_q;
    cnt_d      = cnt_q;
    wb_we_d    = wb_we_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (ex_valid_i) begin
          we_d       = mem_write_en_i;
          f3_d       = funct3_i;
          sdata_d    = store_data_i;
          addr_d     = w_addr_algn;
          err_addr_d = w_addr_raw;
          cnt_d      = '0;
          wb_we_d    = 1'b0;
          wb_data_d  = '0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          if (!mem_read_en_i && !mem_write_en_i) begin
            state_d   = ST_RESP;
            wb_we_d   = 1'b1;
            wb_data_d = alu_result_i;
          end else if (!w_legal) begin
            state_d    = ST_RESP;
            err_d      = 1'b1;
            err_code_d = ERR_ILLEGAL;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (w_mis) begin
            state_d    = ST_RESP;
            err_d      = 1'b1;
            err_code_d = ERR_MISALIGN;
          end
`endif
          else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (dmem_gnt_i) begin
          if (we_q) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT_RSP;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (dmem_rvalid_i) begin
          state_d   = ST_RESP;
          wb_we_d   = 1'b1;
          wb_data_d = w_load_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_RESP;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      f3_q       <= 3'b000;
      addr_q     <= '0;
      sdata_q    <= '0;
      cnt_q      <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      sdata_q    <= sdata_d;
      cnt_q      <= cnt_d;
      wb_we_q    <= wb_we_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Outputs are qualified by state so everything reads zero outside its phase.
  assign w_req        = (state_q == ST_REQ);
  assign w_resp       = (state_q == ST_RESP);
  assign ex_ready_o   = (state_q == ST_IDLE);
  assign done_o       = w_resp;
  assign wb_we_o      = w_resp & wb_we_q;
  assign wb_data_o    = w_resp ? wb_data_q : '0;
  assign err_o        = w_resp & err_q;
  assign err_code_o   = err_o ? err_code_q : ERR_NONE;
  assign err_addr_o   = err_o ? err_addr_q : '0;
  assign dmem_req_o   = w_req;
  assign dmem_we_o    = w_req & we_q;
  assign dmem_addr_o  = w_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dmem_be_o    = w_req ? w_be : '0;
  assign dmem_wdata_o = w_req ? w_wdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed self-checking bench for load_store_unit (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i, ex_ready_o, mem_read_en_i, mem_write_en_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, store_data_i;
  logic        done_o, wb_we_o, err_o;
  logic [31:0] wb_data_o, err_addr_o;
  logic [1:0]  err_code_o;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i;
  logic [3:0]  dmem_be_o;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.XLEN(32), .ADDR_W(32), .RSP_TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid_i     (ex_valid_i),
    .ex_ready_o     (ex_ready_o),
    .mem_read_en_i  (mem_read_en_i),
    .mem_write_en_i (mem_write_en_i),
    .funct3_i       (funct3_i),
    .alu_result_i   (alu_result_i),
    .store_data_i   (store_data_i),
    .done_o         (done_o),
    .wb_we_o        (wb_we_o),
    .wb_data_o      (wb_data_o),
    .err_o          (err_o),
    .err_code_o     (err_code_o),
    .err_addr_o     (err_addr_o),
    .dmem_req_o     (dmem_req_o),
    .dmem_we_o      (dmem_we_o),
    .dmem_addr_o    (dmem_addr_o),
    .dmem_be_o      (dmem_be_o),
    .dmem_wdata_o   (dmem_wdata_o),
    .dmem_gnt_i     (dmem_gnt_i),
    .dmem_rvalid_i  (dmem_rvalid_i),
    .dmem_rdata_i   (dmem_rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    check_eq("ex_ready_idle", ex_ready_o, 1);
    ex_valid_i = 1'b1; mem_read_en_i = rd; mem_write_en_i = wr;
    funct3_i = f3; alu_result_i = a; store_data_i = sd;
    tick();
    ex_valid_i = 1'b0; mem_read_en_i = 1'b0; mem_write_en_i = 1'b0;
  endtask

  // Load with grant in the first REQ cycle and rvalid one cycle later.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] exp_data);
    issue(1'b1, 1'b0, f3, a, 32'h0);
    check_eq({tag, "_req"},   dmem_req_o, 1);
    check_eq({tag, "_ready"}, ex_ready_o, 0);
    check_eq({tag, "_we"},    dmem_we_o, 0);
    check_eq({tag, "_addr"},  dmem_addr_o, exp_addr);
    check_eq({tag, "_be"},    dmem_be_o, exp_be);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check_eq({tag, "_req_drop"}, dmem_req_o, 0);
    check_eq({tag, "_early_done"}, done_o, 0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    check_eq({tag, "_done"},  done_o, 1);
    check_eq({tag, "_wb_we"}, wb_we_o, 1);
    check_eq({tag, "_data"},  wb_data_o, exp_data);
    check_eq({tag, "_err"},   err_o, 0);
    tick();
    check_eq({tag, "_done_1cyc"}, done_o, 0);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int gnt_delay,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata);
    issue(1'b0, 1'b1, f3, a, sd);
    for (int i = 0; i < gnt_delay; i++) begin
      check_eq({tag, "_req_hold"}, dmem_req_o, 1);
      tick();
    end
    check_eq({tag, "_req"},   dmem_req_o, 1);
    check_eq({tag, "_we"},    dmem_we_o, 1);
    check_eq({tag, "_addr"},  dmem_addr_o, exp_addr);
    check_eq({tag, "_be"},    dmem_be_o, exp_be);
    check_eq({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    check_eq({tag, "_done"},  done_o, 1);
    check_eq({tag, "_wb_we"}, wb_we_o, 0);
    check_eq({tag, "_err"},   err_o, 0);
    check_eq({tag, "_req_off"}, dmem_req_o, 0);
    tick();
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    ex_valid_i = 1'b0; mem_read_en_i = 1'b0; mem_write_en_i = 1'b0;
    funct3_i = 3'b000; alu_result_i = '0; store_data_i = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    check_eq("rst_ready", ex_ready_o, 1);
    check_eq("rst_done",  done_o, 0);
    check_eq("rst_req",   dmem_req_o, 0);
    check_eq("rst_err",   err_o, 0);
    check_eq("rst_wdata", wb_data_o, 0);
    rst_n = 1'b1;
    tick();

    do_load("lw",  3'b010, 32'h104, 32'hDEADBEEF, 32'h104, 4'b1111, 32'hDEADBEEF);
    do_load("lb",  3'b000, 32'h103, 32'h80FF0000, 32'h100, 4'b1000, 32'hFFFFFF80);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF0000, 32'h100, 4'b1000, 32'h00000080);
    do_load("lh",  3'b001, 32'h102, 32'h8001_1234, 32'h100, 4'b1100, 32'hFFFF8001);
    do_load("lhu", 3'b101, 32'h102, 32'h8001_1234, 32'h100, 4'b1100, 32'h00008001);

    do_store("sh", 3'b001, 32'h102, 32'h1234ABCD, 3, 32'h100, 4'b1100, 32'hABCD0000);
    do_store("sb", 3'b000, 32'h101, 32'h1234ABCD, 0, 32'h100, 4'b0010, 32'h34ABCD00);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
    check_eq("mis_req",  dmem_req_o, 0);
    check_eq("mis_done", done_o, 1);
    check_eq("mis_err",  err_o, 1);
    check_eq("mis_code", err_code_o, 2'b01);
    check_eq("mis_addr", err_addr_o, 32'h101);
    tick();
`else
    do_load("lw_mis", 3'b010, 32'h101, 32'h11223344, 32'h100, 4'b1111, 32'h11223344);
`endif

    // Response timeout, then a late rvalid that must be ignored
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    n = 0;
    while (!done_o && n < 100) begin
      tick();
      n++;
    end
    check_eq("to_latency", n, 16);
    check_eq("to_err",   err_o, 1);
    check_eq("to_code",  err_code_o, 2'b10);
    check_eq("to_wb_we", wb_we_o, 0);
    check_eq("to_addr",  err_addr_o, 32'h200);
    tick();
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hCAFEF00D;
    tick();
    dmem_rvalid_i = 1'b0;
    check_eq("late_rvalid_done", done_o, 0);
    check_eq("late_rvalid_ready", ex_ready_o, 1);

    // ALU bypass
    issue(1'b0, 1'b0, 3'b000, 32'h55, 32'h0);
    check_eq("byp_done",  done_o, 1);
    check_eq("byp_wb_we", wb_we_o, 1);
    check_eq("byp_data",  wb_data_o, 32'h55);
    check_eq("byp_req",   dmem_req_o, 0);
    tick();

    // Both enables set
    issue(1'b1, 1'b1, 3'b010, 32'h300, 32'h0);
    check_eq("ill_done", done_o, 1);
    check_eq("ill_err",  err_o, 1);
    check_eq("ill_code", err_code_o, 2'b11);
    check_eq("ill_wbwe", wb_we_o, 0);
    check_eq("ill_req",  dmem_req_o, 0);
    tick();

    // LD is illegal at XLEN=32
    issue(1'b1, 1'b0, 3'b011, 32'h308, 32'h0);
    check_eq("ld_err",  err_o, 1);
    check_eq("ld_code", err_code_o, 2'b11);
    tick();

    // Reset during WAIT_RSP
    issue(1'b1, 1'b0, 3'b010, 32'h400, 32'h0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_ready", ex_ready_o, 1);
    check_eq("mrst_req",   dmem_req_o, 0);
    check_eq("mrst_done",  done_o, 0);
    check_eq("mrst_err",   err_o, 0);
    #2;
    rst_n = 1'b1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h12345678;
    tick();
    dmem_rvalid_i = 1'b0;
    check_eq("mrst_late_done", done_o, 0);
    tick();
    check_eq("mrst_post_done", done_o, 0);

    // Unit still operational after mid-op reset
    do_load("lw_post", 3'b010, 32'h500, 32'h0BADF00D, 32'h500, 4'b1111, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
